sm3_req_arbiter: RTL and testbench
==================================

Name: sm3_req_arbiter

Overview:
- Shares one SM3_Encrypt core (PARALLEL_NUM=1, 256-bit in/out, single-cycle valid pulses) between REQ_NUM requesters, e.g. the ID/recode verify path and UDP-side checks.
- Round-robin grant. One job in flight at a time.
- Sequence per job: accept request, issue to core, wait for digest, return it to the granted requester only.
- Sits between the requesters and the single core instance; it is the only driver of the core's input port.

Parameters:
- REQ_NUM, 4, number of requesters; legal range 2..8.
- DATA_W, 256, request and digest width; fixed to the core width.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only when SM3_ARB_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_data  in  REQ_NUM*DATA_W  request payloads; slice k belongs to requester k.
- i_req_vld  in  REQ_NUM  request valid per requester; held high until accepted.
- o_req_rdy  out  REQ_NUM  accept strobe; one-hot or zero.
- o_rsp_data  out  DATA_W  digest; valid only while a bit of o_rsp_vld is high.
- o_rsp_vld  out  REQ_NUM  one-cycle response pulse; one-hot.
- o_sm3_data  out  DATA_W  to core i_Original_Data.
- o_sm3_vld  out  1  to core i_Original_Valid.
- i_sm3_data  in  DATA_W  from core o_Encrypt_Data.
- i_sm3_vld  in  1  from core o_Encrypt_Valid.
- o_busy  out  1  high in every state except IDLE.
- o_grant_id  out  $clog2(REQ_NUM)  index of the current or last granted requester.

Behaviour:
- Reset values: every output is 0. FSM = IDLE. Round-robin pointer r_last = REQ_NUM-1, so requester 0 wins first.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant = first k with i_req_vld[k]=1, searching r_last+1, r_last+2, ... mod REQ_NUM.
  - o_req_rdy = grant one-hot, combinational, qualified by state==IDLE and a nonzero i_req_vld.
  - On handshake (vld&rdy): latch the slice, latch grant index, go to ISSUE.
  - No i_req_vld bit high: stay in IDLE.
- ISSUE: o_sm3_vld=1 and o_sm3_data=latched payload for exactly one cycle, then WAIT. o_sm3_data=0 whenever o_sm3_vld=0.
- WAIT: on i_sm3_vld, capture i_sm3_data and go to RESP. Otherwise stay.
- RESP:
  - o_rsp_vld[g]=1 and o_rsp_data=captured digest for one cycle.
  - r_last <= g, then IDLE.
  - o_rsp_data returns to 0 the following cycle.
- Latency: core latency + 3 cycles from the accept cycle to the o_rsp_vld cycle. Back-to-back throughput is one job per core latency + 4 cycles.
- i_sm3_vld outside WAIT: ignored, with no state change.
- Requests arriving while busy: not accepted; requesters hold i_req_vld. A request dropped before rdy is legal and simply is not granted.
- Simultaneous requests: round-robin order, with no starvation. With all requesters continuously asserted the grant order is 0,1,2,3,0,...
- Reset mid-operation: FSM and captured data are cleared immediately. No o_rsp_vld is produced for the aborted job. The core shares the reset.
- o_grant_id updates on accept and holds its value through IDLE.

Optional Feature:
- Macro: SM3_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT. If it reaches TIMEOUT_CYC-1 without i_sm3_vld, the block goes to RESP with o_rsp_data=0.
  - Additional output o_rsp_err (REQ_NUM bits) pulses in the same bit as o_rsp_vld.
  - Sticky output o_core_fault is set; the block then stays in IDLE with all o_req_rdy=0 until reset. This prevents a late digest from being attributed to a later job.
- Undefined: no counter and no extra ports; WAIT is unbounded.

Decomposition:
- Shared package sm3_arb_pkg:
  - FSM state encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
  - SM3_DATA_W=256.
  - Default TIMEOUT_CYC.
- One natural sub-module: rr_arbiter. It is pure combinational round-robin grant logic (request vector + pointer -> one-hot grant + index), reusable elsewhere.

Test Plan:
Bench core model: digest = ~input, returned exactly 64 cycles after the valid pulse.
1. Single request: req1 with data=256'h1234 -> o_sm3_vld one cycle after accept; o_rsp_vld=4'b0010 and o_rsp_data=~256'h1234 exactly 67 cycles after accept.
2. All four requesting simultaneously from reset -> grants in order 0,1,2,3. Each requester gets exactly one o_rsp_vld with its own inverted payload. Responses are 68 cycles apart.
3. req2 held continuously while req0 pulses each time the block returns to IDLE -> grants alternate 2,0,2,0; neither starves.
4. Spurious i_sm3_vld injected in IDLE and ISSUE -> no o_rsp_vld, FSM unchanged; the next real job still returns the correct digest.
5. i_rst_n asserted at cycle 30 of WAIT -> all outputs 0 the same cycle. No response for the aborted job; the first request after reset goes to requester 0.
6. (SM3_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, core stalled) -> o_rsp_vld and o_rsp_err pulse 16 cycles into WAIT with data 0. o_core_fault=1 and o_req_rdy stays 0 until reset.

Source files
------------

// File: rtl/sm3_arb_pkg.sv
// Shared definitions for the SM3 request arbiter.
//   arb_state_e     : arbiter FSM encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   SM3_DATA_W      : SM3 core input/digest width
//   SM3_TIMEOUT_CYC : default watchdog limit, used only with SM3_ARB_TIMEOUT_EN
package sm3_arb_pkg;

  localparam int unsigned SM3_DATA_W      = 256;
  localparam int unsigned SM3_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant.
//   req     : request vector
//   last    : index of the previous winner; the search starts at last+1
//   gnt     : one-hot grant, zero when req is zero
//   gnt_idx : index of the granted bit, zero when req is zero
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    // i = N wraps back to the last winner itself, so a lone requester always wins.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IDX_W'((32'(last) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sm3_req_arbiter.sv
// Shares one SM3 core between REQ_NUM requesters, one job at a time, round-robin.
// Flow per job: IDLE (accept) -> ISSUE (pulse core) -> WAIT (digest) -> RESP (return).
// Ports:
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_req_data / i_req_vld   : per-requester payload slices and valids
//   o_req_rdy                : one-hot accept strobe (IDLE only)
//   o_rsp_data / o_rsp_vld   : digest and one-hot response pulse to the granted requester
//   o_sm3_data / o_sm3_vld   : core input (data is zero outside the valid pulse)
//   i_sm3_data / i_sm3_vld   : core digest output
//   o_busy                   : high whenever the FSM is not IDLE
//   o_grant_id               : current or last granted requester
// Optional SM3_ARB_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT_CYC) plus o_rsp_err
// and the sticky o_core_fault; after a timeout no further requests are accepted.
module sm3_req_arbiter
  import sm3_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM     = 4,
  parameter int unsigned DATA_W      = SM3_DATA_W
`ifdef SM3_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = SM3_TIMEOUT_CYC
`endif
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [REQ_NUM*DATA_W-1:0]  i_req_data,
  input  logic [REQ_NUM-1:0]         i_req_vld,
  output logic [REQ_NUM-1:0]         o_req_rdy,
  output logic [DATA_W-1:0]          o_rsp_data,
  output logic [REQ_NUM-1:0]         o_rsp_vld,
  output logic [DATA_W-1:0]          o_sm3_data,
  output logic                       o_sm3_vld,
  input  logic [DATA_W-1:0]          i_sm3_data,
  input  logic                       i_sm3_vld,
  output logic                       o_busy,
  output logic [$clog2(REQ_NUM)-1:0] o_grant_id
`ifdef SM3_ARB_TIMEOUT_EN
  ,
  output logic [REQ_NUM-1:0]         o_rsp_err,
  output logic                       o_core_fault
`endif
);

  localparam int unsigned IDX_W = $clog2(REQ_NUM);

  arb_state_e         state_q, state_d;
  logic [DATA_W-1:0]  payload_q, digest_q, sel_data;
  logic [IDX_W-1:0]   gid_q, last_q, gnt_idx;
  logic [REQ_NUM-1:0] gnt, req_rdy, gid_onehot;
  logic               fault, timeout;

  rr_arbiter #(
    .N     (REQ_NUM),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (i_req_vld),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gid_onehot = {{(REQ_NUM-1){1'b0}}, 1'b1} << gid_q;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (gnt[k]) sel_data = i_req_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef SM3_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q;
  logic             fault_q;

  // A digest arriving on the last counted cycle still wins over the timeout.
  assign timeout = (state_q == StWait) && !i_sm3_vld &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= (state_q == StWait) ? cnt_q + CNT_W'(1) : '0;
      fault_q <= fault_q | timeout;
    end
  end

  assign fault        = fault_q;
  assign o_core_fault = fault_q;
  // Only the timed-out job can reach RESP with the fault set.
  assign o_rsp_err    = (state_q == StResp && fault_q) ? gid_onehot : '0;
`else
  assign fault   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_rdy    = '0;
    o_sm3_vld  = 1'b0;
    o_sm3_data = '0;
    o_rsp_vld  = '0;
    o_rsp_data = '0;
    unique case (state_q)
      StIdle: begin
        // Reset qualification keeps every output at 0 while i_rst_n is held low.
        if (i_rst_n && !fault) req_rdy = gnt;
        if (|req_rdy) state_d = StIssue;
      end
      StIssue: begin
        o_sm3_vld  = 1'b1;
        o_sm3_data = payload_q;
        state_d    = StWait;
      end
      StWait: begin
        if (i_sm3_vld || timeout) state_d = StResp;
      end
      StResp: begin
        o_rsp_vld  = gid_onehot;
        o_rsp_data = digest_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      payload_q <= '0;
      digest_q  <= '0;
      gid_q     <= '0;
      last_q    <= IDX_W'(REQ_NUM - 1);
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && |req_rdy) begin
        payload_q <= sel_data;
        gid_q     <= gnt_idx;
      end
      if (state_q == StWait) begin
        if (i_sm3_vld)    digest_q <= i_sm3_data;
        else if (timeout) digest_q <= '0;
      end
      if (state_q == StResp) last_q <= gid_q;
    end
  end

  assign o_req_rdy  = req_rdy;
  assign o_busy     = (state_q != StIdle);
  assign o_grant_id = gid_q;

endmodule

// File: tb/tb_sm3_req_arbiter.sv
// Bench for sm3_req_arbiter: a behavioural core (digest = ~input after a fixed delay),
// a round-robin reference model, and a response scoreboard checked by a monitor.
module tb_sm3_req_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 256;
`ifdef SM3_ARB_TIMEOUT_EN
  localparam int CORE_LAT = 8;
  localparam int TO_CYC   = 16;
`else
  localparam int CORE_LAT = 64;
`endif

  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           due;
    bit           err;
  } exp_t;

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } core_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_vld = '0;
  logic [N-1:0]   req_rdy;
  logic [W-1:0]   rsp_data;
  logic [N-1:0]   rsp_vld;
  logic [W-1:0]   sm3_data_o;
  logic           sm3_vld_o;
  logic [W-1:0]   sm3_data_i = '0;
  logic           sm3_vld_i = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;
`ifdef SM3_ARB_TIMEOUT_EN
  logic [N-1:0]   rsp_err;
  logic           core_fault;
`endif

  logic [W-1:0] pay [N];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state.
  bit           m_busy, m_fault;
  int           m_last, m_gid, m_acc_cyc, pick;
  logic [W-1:0] m_pay;
  logic [N-1:0] exp_rdy, acc_mask;
  exp_t         sb[$];
  core_t        core_q[$];
  int           glog[$];
  int           rsp_cyc[$];
  exp_t         e;
  core_t        c;
  bit           core_stall = 1'b0;
  bit           spur = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < N; k++) req_data[k*W +: W] = pay[k];
  end

  sm3_req_arbiter #(
    .REQ_NUM     (N),
    .DATA_W      (W)
`ifdef SM3_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TO_CYC)
`endif
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_data   (req_data),
    .i_req_vld    (req_vld),
    .o_req_rdy    (req_rdy),
    .o_rsp_data   (rsp_data),
    .o_rsp_vld    (rsp_vld),
    .o_sm3_data   (sm3_data_o),
    .o_sm3_vld    (sm3_vld_o),
    .i_sm3_data   (sm3_data_i),
    .i_sm3_vld    (sm3_vld_i),
    .o_busy       (busy),
    .o_grant_id   (grant_id)
`ifdef SM3_ARB_TIMEOUT_EN
    ,
    .o_rsp_err    (rsp_err),
    .o_core_fault (core_fault)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic fail_msg(input string name, input string detail);
    checks++;
    failures++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  // Round-robin rule: first requester found searching last+1, last+2, ... mod N.
  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    logic [N-1:0] r;
    for (int s = 1; s <= N; s++) begin
      r = req >> ((last + s) % N);
      if (r[0]) return (last + s) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural SM3 core: digest = ~input, CORE_LAT edges after the pulse is sampled.
  always begin
    @(posedge clk);
    #2;
    sm3_vld_i  = 1'b0;
    sm3_data_i = '0;
    if (rst_n) begin
      while (core_q.size() > 0 && core_q[0].due < cyc) void'(core_q.pop_front());
      if (core_q.size() > 0 && core_q[0].due == cyc) begin
        c = core_q.pop_front();
        if (!core_stall) begin
          sm3_vld_i  = 1'b1;
          sm3_data_i = c.data;
        end
      end else if (spur) begin
        sm3_vld_i  = 1'b1;
        sm3_data_i = rnd();
      end
    end
  end

  // Monitor: reference grant model plus response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      pick    = (m_busy || m_fault) ? -1 : rr_pick(m_last, req_vld);
      exp_rdy = '0;
      if (pick >= 0) exp_rdy = N'(1) << pick;
      chk("req_rdy", W'(req_rdy), W'(exp_rdy));
      chk("busy", W'(busy), W'(m_busy));
      chk("grant_id", W'(grant_id), W'(m_gid));
      chk("sm3_vld", W'(sm3_vld_o), W'(m_busy && cyc == m_acc_cyc + 1));
      chk("sm3_data", sm3_data_o, (m_busy && cyc == m_acc_cyc + 1) ? m_pay : '0);
      if (sm3_vld_o) begin
        c.due  = cyc + CORE_LAT + 1;
        c.data = ~sm3_data_o;
        core_q.push_back(c);
      end
      if (rsp_vld != '0) begin
        if (sb.size() == 0) begin
          fail_msg("rsp_unexpected", $sformatf("got rsp_vld %b, required none", rsp_vld));
        end else begin
          e = sb.pop_front();
          chk("rsp_vld", W'(rsp_vld), W'(N'(1) << e.id));
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_cycle", W'(cyc), W'(e.due));
`ifdef SM3_ARB_TIMEOUT_EN
          chk("rsp_err", W'(rsp_err), e.err ? W'(N'(1) << e.id) : '0);
          if (e.err) m_fault = 1'b1;
`endif
          rsp_cyc.push_back(cyc);
          m_last = e.id;
          m_busy = 1'b0;
        end
      end else begin
        chk("rsp_data_idle", rsp_data, '0);
`ifdef SM3_ARB_TIMEOUT_EN
        chk("rsp_err_idle", W'(rsp_err), '0);
`endif
        if (sb.size() > 0 && cyc > sb[0].due) begin
          e = sb.pop_front();
          fail_msg("rsp_missing", $sformatf("got no response, required one for req %0d", e.id));
          m_last = e.id;
          m_busy = 1'b0;
        end
      end
`ifdef SM3_ARB_TIMEOUT_EN
      chk("core_fault", W'(core_fault), W'(m_fault));
`endif
      acc_mask = req_vld & req_rdy;
      if (pick >= 0) begin
        m_busy    = 1'b1;
        m_acc_cyc = cyc;
        m_gid     = pick;
        m_pay     = pay[pick];
        glog.push_back(pick);
        e.id   = pick;
        e.data = ~pay[pick];
        e.due  = cyc + CORE_LAT + 3;
        e.err  = 1'b0;
`ifdef SM3_ARB_TIMEOUT_EN
        if (core_stall) begin
          e.data = '0;
          e.due  = cyc + TO_CYC + 2;
          e.err  = 1'b1;
        end
`endif
        sb.push_back(e);
      end
    end
  end

  task automatic model_reset();
    m_busy   = 1'b0;
    m_fault  = 1'b0;
    m_last   = N - 1;
    m_gid    = 0;
    acc_mask = '0;
    req_vld  = '0;
    sb.delete();
    core_q.delete();
    glog.delete();
    rsp_cyc.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_rdy"}, W'(req_rdy), '0);
    chk({tag, "_rsp_vld"}, W'(rsp_vld), '0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
    chk({tag, "_sm3_vld"}, W'(sm3_vld_o), '0);
    chk({tag, "_sm3_data"}, sm3_data_o, '0);
    chk({tag, "_busy"}, W'(busy), '0);
    chk({tag, "_grant_id"}, W'(grant_id), '0);
`ifdef SM3_ARB_TIMEOUT_EN
    chk({tag, "_rsp_err"}, W'(rsp_err), '0);
    chk({tag, "_core_fault"}, W'(core_fault), '0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req_vld = req_vld & ~acc_mask;
    acc_mask = '0;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic raise(input int k, input logic [W-1:0] d);
    pay[k]     = d;
    req_vld[k] = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!m_busy && sb.size() == 0 && req_vld == '0) break;
      tick();
    end
    if (i == budget) fail_msg(tag, "got still busy, required idle within budget");
  endtask

  initial begin
    int exp_rr[4];
    for (int k = 0; k < N; k++) pay[k] = '0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single request from requester 1.
    raise(1, 256'h1234);
    wait_idle("t1_idle", 300);
    chk("t1_count", W'(glog.size()), W'(1));
    if (glog.size() > 0) chk("t1_grant", W'(glog[0]), W'(1));

    // 2: all four at once from reset, grants 0..3, responses CORE_LAT+4 apart.
    do_reset("t2_rst");
    for (int k = 0; k < N; k++) raise(k, rnd());
    wait_idle("t2_idle", 600);
    exp_rr = '{0, 1, 2, 3};
    chk("t2_count", W'(glog.size()), W'(4));
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("t2_order", W'(glog[i]), W'(exp_rr[i]));
    for (int i = 1; i < 4 && i < rsp_cyc.size(); i++)
      chk("t2_spacing", W'(rsp_cyc[i] - rsp_cyc[i-1]), W'(CORE_LAT + 4));

    // 3: req2 held, req0 re-raised while busy -> 2,0,2,0.
    do_reset("t3_rst");
    raise(2, rnd());
    for (int i = 0; i < 800 && glog.size() < 4; i++) begin
      tick();
      if (!req_vld[2]) raise(2, rnd());
      if (m_busy && !req_vld[0]) raise(0, rnd());
    end
    req_vld = '0;
    wait_idle("t3_idle", 300);
    exp_rr = '{2, 0, 2, 0};
    for (int i = 0; i < 4; i++) begin
      if (i < glog.size()) chk("t3_order", W'(glog[i]), W'(exp_rr[i]));
      else fail_msg("t3_order", "got too few grants, required four");
    end

    // 4: spurious core valid in IDLE and ISSUE.
    spur = 1'b1;
    repeat (6) tick();
    raise(3, rnd());
    for (int i = 0; i < 50 && !(m_busy && cyc == m_acc_cyc + 1); i++) tick();
    tick();
    spur = 1'b0;
    wait_idle("t4_idle", 300);

    // 5: reset during WAIT, then requester 0 wins first.
    raise(2, rnd());
    for (int i = 0; i < 200 && !(m_busy && cyc == m_acc_cyc + 32); i++) tick();
    chk("t5_in_wait", W'(m_busy && cyc == m_acc_cyc + 32), W'(1));
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("t5_abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) raise(k, rnd());
    wait_idle("t5_idle", 600);
    if (glog.size() > 0) chk("t5_first", W'(glog[0]), W'(0));
    else fail_msg("t5_first", "got no grant, required requester 0");

    // Randomized traffic with occasional legal drops and spurious core pulses.
    for (int i = 0; i < 2000; i++) begin
      tick();
      spur = ($urandom_range(7) == 0) && !m_busy;
      for (int k = 0; k < N; k++) begin
        if (!req_vld[k] && $urandom_range(3) == 0) raise(k, rnd());
        else if (req_vld[k] && $urandom_range(63) == 0) req_vld[k] = 1'b0;
      end
    end
    tick();
    spur = 1'b0;
    req_vld = '0;
    wait_idle("rand_idle", 300);

`ifdef SM3_ARB_TIMEOUT_EN
    // 6: stalled core -> timeout response, sticky fault, no further grants.
    do_reset("t6_rst");
    core_stall = 1'b1;
    raise(1, rnd());
    for (int i = 0; i < 100 && !m_fault; i++) tick();
    chk("t6_fault_model", W'(m_fault), W'(1));
    for (int k = 0; k < N; k++) raise(k, rnd());
    repeat (20) tick();
    chk("t6_fault", W'(core_fault), W'(1));
    chk("t6_rdy", W'(req_rdy), '0);
    core_stall = 1'b0;
    do_reset("t6_clear");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion, required finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
